// File: rtl/demux1to3_buf.sv
// ---------------------------------------------------------------------------
// demux1to3_buf
//
// Buffered 1-to-3 data distributor. One producer offers an 8-bit word with a
// 3-bit destination select. The word is delivered to one of three consumers
// through a one-entry holding register per channel, each with a valid/ready
// handshake. Select codes 3'b011..3'b111 are accepted and discarded, and are
// counted in a saturating 8-bit error counter.
//
// Ports:
//   clock                  rising-edge clock for all state
//   reset_n                asynchronous, active-low reset
//   in_data   [7:0]        word to distribute
//   in_sel    [2:0]        destination: 000->ch0, 001->ch1, 010->ch2, else discard
//   in_valid               producer offers in_data/in_sel this cycle
//   in_ready               block accepts this cycle (combinational, no in_valid path)
//   data0x/data1x/data2x   channel holding-register contents
//   valid0/valid1/valid2   channel holds an undelivered word
//   ready0/ready1/ready2   consumer takes the channel word this cycle
//   err_count [7:0]        saturating count of discarded words
// ---------------------------------------------------------------------------
module demux1to3_buf (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic [2:0] in_sel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] data0x,
    output logic [7:0] data1x,
    output logic [7:0] data2x,
    output logic       valid0,
    output logic       valid1,
    output logic       valid2,
    input  logic       ready0,
    input  logic       ready1,
    input  logic       ready2,
    output logic [7:0] err_count
);

    // Slot storage, indexed by channel number.
    logic [7:0] data_p0 [3];
    logic [2:0] vld_p0;
    logic [7:0] err_p0;

    logic [2:0] rdy;
    logic [2:0] fill;
    logic [2:0] drain;
    logic       xfer;
    logic       discard;

    // Saturating increment: holds at 8'hFF instead of wrapping to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end
        return v + 8'd1;
    endfunction

    assign rdy = {ready2, ready1, ready0};

    // A mapped channel can accept when empty or when its word leaves this
    // same edge; this lets a streaming channel sustain one word per cycle.
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            3'b000:  in_ready = !vld_p0[0] || rdy[0];
            3'b001:  in_ready = !vld_p0[1] || rdy[1];
            3'b010:  in_ready = !vld_p0[2] || rdy[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign xfer    = in_valid && in_ready;
    assign discard = xfer && (in_sel > 3'b010);

    always_comb begin
        fill = 3'b000;
        for (int k = 0; k < 3; k++) begin
            fill[k] = xfer && (in_sel == 3'(k));
        end
    end

    // ready k only matters while the slot actually holds a word.
    assign drain = vld_p0 & rdy;

    // ---- stage p0: holding registers and error counter ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 3'b000;
            err_p0 <= 8'h00;
            for (int k = 0; k < 3; k++) begin
                data_p0[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                // Fill wins over drain: a simultaneous take-and-refill keeps
                // the slot valid with the new word.
                if (fill[k]) begin
                    data_p0[k] <= in_data;
                    vld_p0[k]  <= 1'b1;
                end else if (drain[k]) begin
                    vld_p0[k]  <= 1'b0;
                end
            end
            if (discard) begin
                err_p0 <= sat_inc8(err_p0);
            end
        end
    end

    assign data0x    = data_p0[0];
    assign data1x    = data_p0[1];
    assign data2x    = data_p0[2];
    assign valid0    = vld_p0[0];
    assign valid1    = vld_p0[1];
    assign valid2    = vld_p0[2];
    assign err_count = err_p0;

endmodule

// File: tb/tb_demux1to3_buf.sv
// ---------------------------------------------------------------------------
// tb_demux1to3_buf
//
// Self-checking bench for demux1to3_buf: directed scenarios followed by a
// randomized run, all compared against a behavioural slot model and a
// per-channel queue of accepted words.
// ---------------------------------------------------------------------------
module tb_demux1to3_buf;

    logic       clock;
    logic       reset_n;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data0x, data1x, data2x;
    logic       valid0, valid1, valid2;
    logic       ready0, ready1, ready2;
    logic [7:0] err_count;

    demux1to3_buf dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data0x    (data0x),
        .data1x    (data1x),
        .data2x    (data2x),
        .valid0    (valid0),
        .valid1    (valid1),
        .valid2    (valid2),
        .ready0    (ready0),
        .ready1    (ready1),
        .ready2    (ready2),
        .err_count (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: slot contents, error count, and words accepted but
    // not yet taken by each consumer.
    logic [7:0] md [3];
    logic       mv [3];
    int         merr;
    logic [7:0] accq [3][$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_data(input int k);
        case (k)
            0: return data0x;
            1: return data1x;
            default: return data2x;
        endcase
    endfunction

    function automatic logic dut_valid(input int k);
        case (k)
            0: return valid0;
            1: return valid1;
            default: return valid2;
        endcase
    endfunction

    function automatic logic model_ready(input logic [2:0] s, input logic [2:0] r);
        if (s > 3'd2) return 1'b1;
        return !mv[s] || r[s];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            md[k] = 8'h00;
            mv[k] = 1'b0;
            accq[k].delete();
        end
        merr = 0;
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s valid%0d", tag, k), 32'(dut_valid(k)), 32'(mv[k]));
            check($sformatf("%s data%0d", tag, k), 32'(dut_data(k)), 32'(md[k]));
        end
        check($sformatf("%s err_count", tag), 32'(err_count), 32'(merr));
    endtask

    // One clock cycle: drive inputs (called just after a falling edge),
    // check in_ready, advance the model at the rising edge, check outputs.
    task automatic step(input string tag, input logic v, input logic [2:0] s,
                        input logic [7:0] d, input logic [2:0] r);
        logic acc;
        in_valid = v; in_sel = s; in_data = d;
        ready0 = r[0]; ready1 = r[1]; ready2 = r[2];
        #1;
        acc = model_ready(s, r);
        check({tag, " in_ready"}, 32'(in_ready), 32'(acc));
        @(posedge clock);
        // Consumers take the words that were waiting before this edge.
        for (int k = 0; k < 3; k++) begin
            if (mv[k] && r[k]) begin
                if (accq[k].size() == 0) begin
                    check($sformatf("%s take%0d queue", tag, k), 32'd0, 32'd1);
                end else begin
                    check($sformatf("%s take%0d word", tag, k), 32'(md[k]), 32'(accq[k].pop_front()));
                end
                mv[k] = 1'b0;
            end
        end
        if (v && acc) begin
            if (s <= 3'd2) begin
                md[s] = d;
                mv[s] = 1'b1;
                accq[s].push_back(d);
            end else if (merr < 255) begin
                merr++;
            end
        end
        #1;
        check_outputs(tag);
        @(negedge clock);
    endtask

    logic       pend;
    logic       hv;
    logic [2:0] hs;
    logic [7:0] hd;
    int         rsel;

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00;
        ready0 = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_outputs("reset");
        reset_n = 1'b1;

        // Single word to ch0, taken on the following edge.
        step("t1a", 1'b1, 3'd0, 8'hA5, 3'b001);
        step("t1b", 1'b0, 3'd0, 8'h00, 3'b001);

        // Streaming to ch1 with the consumer always ready.
        for (int i = 1; i <= 4; i++) begin
            step($sformatf("t2_%0d", i), 1'b1, 3'd1, 8'(i), 3'b010);
        end
        step("t2_end", 1'b0, 3'd1, 8'h00, 3'b010);

        // Backpressure on ch2, ch0 still accepted during the stall.
        step("t3_fill", 1'b1, 3'd2, 8'h3C, 3'b000);
        step("t3_stall", 1'b1, 3'd2, 8'h77, 3'b000);
        step("t3_ch0", 1'b1, 3'd0, 8'h11, 3'b000);
        step("t3_stall2", 1'b1, 3'd2, 8'h77, 3'b000);
        step("t3_go", 1'b1, 3'd2, 8'h77, 3'b101);
        step("t3_drain", 1'b0, 3'd0, 8'h00, 3'b111);

        // Unmapped selects, then saturation of the error counter.
        step("t4_011", 1'b1, 3'd3, 8'h01, 3'b000);
        step("t4_100", 1'b1, 3'd4, 8'h02, 3'b000);
        step("t4_111", 1'b1, 3'd7, 8'h03, 3'b000);
        for (int i = 0; i < 260; i++) begin
            step("t4_sat", 1'b1, 3'(3 + (i % 5)), 8'(i), 3'b000);
        end
        check("t4 saturated", 32'(err_count), 32'hFF);

        // Fill all channels, then assert reset between clock edges.
        step("t5_f0", 1'b1, 3'd0, 8'hC0, 3'b000);
        step("t5_f1", 1'b1, 3'd1, 8'hC1, 3'b000);
        step("t5_f2", 1'b1, 3'd2, 8'hC2, 3'b000);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("t5_async");
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #0.1;
            check($sformatf("t5 in_ready sel%0d", s), 32'(in_ready), 32'd1);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic; an offered word is held until accepted.
        pend = 1'b0;
        hv = 1'b0; hs = 3'd0; hd = 8'h00;
        for (int i = 0; i < 600; i++) begin
            logic [2:0] r;
            if (!pend) begin
                hv = ($urandom_range(0, 3) != 0);
                rsel = $urandom_range(0, 9);
                hs = (rsel < 8) ? 3'(rsel % 3) : 3'(3 + (rsel % 5));
                hd = 8'($urandom);
            end
            r = 3'($urandom);
            pend = hv && !model_ready(hs, r);
            step("rand", hv, hs, hd, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
